// File: rtl/ocp_out_serializer.sv
// Vector FIFO that streams OCP_NUM-wide result vectors out one channel per beat.
// Optional OCP_SER_STATS_EN adds saturating accepted/dropped counters.
module ocp_out_serializer #(
  parameter int OCP_NUM = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OCP_NUM*DATA_W-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(OCP_NUM)-1:0]  out_ch,
  output logic                        out_last
`ifdef OCP_SER_STATS_EN
  ,
  output logic [15:0]                 stat_vec_cnt,
  output logic [15:0]                 stat_drop_cnt
`endif
);

  localparam int CW = $clog2(OCP_NUM);
  localparam int AW = $clog2(DEPTH);

  typedef logic [OCP_NUM-1:0][DATA_W-1:0] vec_t;

  vec_t          r_mem [DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic [CW-1:0] r_ch;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_beat;
  logic w_last;
  vec_t w_head;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = in_valid && !w_full;
  assign w_beat  = !w_empty && out_ready;
  assign w_last  = (r_ch == CW'(OCP_NUM - 1));
  assign w_head  = r_mem[r_rd[AW-1:0]];

  // Storage carries no reset; emptiness is tracked by the pointers only.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_ch <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + (AW+1)'(1);
      if (w_beat) begin
        if (w_last) begin
          r_ch <= '0;
          r_rd <= r_rd + (AW+1)'(1);
        end else begin
          r_ch <= r_ch + CW'(1);
        end
      end
    end
  end

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_head[r_ch];
  assign out_ch    = w_empty ? '0 : r_ch;
  assign out_last  = !w_empty && w_last;

`ifdef OCP_SER_STATS_EN
  logic [15:0] r_vec_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vec_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push && r_vec_cnt != 16'hFFFF)
        r_vec_cnt <= r_vec_cnt + 16'd1;
      if (in_valid && w_full && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign stat_vec_cnt  = r_vec_cnt;
  assign stat_drop_cnt = r_drop_cnt;
`endif

endmodule
